// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin merge of two buffered writeback streams onto one registered RF write port
module regfile_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [4:0]        a_rd,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [4:0]        b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              write_enable,
  output logic [4:0]        write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              grant_b,
  output logic              idle
);
  localparam int W = DATA_W + 5;
  logic a_full, a_empty, b_full, b_empty, last_b, sel_b, pop_a, pop_b;
  logic [W-1:0] a_head, b_head;
  assign a_ready = !a_full;
  assign b_ready = !b_full;
  // writes to r0 complete the handshake but are dropped here
  regfile_wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fa (
    .clk(clk), .rst_n(rst_n), .push(a_valid && a_ready && a_rd != 5'd0), .pop(pop_a),
    .din({a_rd, a_data}), .dout(a_head), .full(a_full), .empty(a_empty)
  );
  regfile_wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fb (
    .clk(clk), .rst_n(rst_n), .push(b_valid && b_ready && b_rd != 5'd0), .pop(pop_b),
    .din({b_rd, b_data}), .dout(b_head), .full(b_full), .empty(b_empty)
  );
  assign sel_b = !b_empty && (a_empty || !last_b);
  assign pop_a = !a_empty && !sel_b;
  assign pop_b = sel_b;
  assign idle = a_empty && b_empty && !write_enable;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      write_enable <= 1'b0;
      write_reg <= '0;
      write_data <= '0;
      grant_b <= 1'b0;
      last_b <= 1'b1;
    end else begin
      write_enable <= pop_a || pop_b;
      if (pop_a || pop_b) begin
        {write_reg, write_data} <= sel_b ? b_head : a_head;
        grant_b <= sel_b;
        last_b <= sel_b;
      end
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: A = ALU result path, B = load/memory result path.
- Each requester has a small in-order FIFO; a round-robin arbiter drains the FIFO heads onto a registered write port.
- Sits between execute/memory stages and the register file; its outputs drive the register file's write_enable/write_reg/write_data directly.

Parameters:
- DEPTH, 2, entries per requester FIFO (power of two, >=2).
- DATA_W, 32, writeback data width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  requester A has a write
- a_ready  out  1  A FIFO can accept
- a_rd  in  5  A destination register
- a_data  in  DATA_W  A write data
- b_valid  in  1  requester B has a write
- b_ready  out  1  B FIFO can accept
- b_rd  in  5  B destination register
- b_data  in  DATA_W  B write data
- write_enable  out  1  register file write strobe (registered)
- write_reg  out  5  register file write address (registered)
- write_data  out  DATA_W  register file write data (registered)
- grant_b  out  1  registered; 1 = current write came from B
- idle  out  1  both FIFOs empty and write_enable low

Behaviour:
- Reset (rst_n low, async): FIFOs empty, pointers 0, write_enable=0, write_reg=0, write_data=0, grant_b=0, RR pointer = "last grant B" (A wins first tie), idle=1. Reset mid-operation discards all buffered writes.
- Ready: x_ready = !fifo_x_full. No dependence on same-cycle pop (no full-FIFO bypass). a_ready=b_ready=1 out of reset.
- Accept: transfer on rising edge when x_valid && x_ready.
- x0 filter: accepted transfer with x_rd==0 is consumed (handshake completes) but not pushed; never reaches the port.
- Arbitration each cycle on FIFO heads:
  - only one non-empty: that one is popped.
  - both non-empty: pop the one not granted last; update RR pointer.
  - none: write_enable=0 next cycle; write_reg/write_data/grant_b hold.
- Pop registers head into write_reg/write_data, sets write_enable=1, grant_b=selected.
- Latency: push at edge N, earliest pop at edge N+1; write_enable high during cycle after N+1; RF commits at edge N+2. Minimum 2 edges from accept to RF update.
- Throughput: one write per cycle total; each FIFO alone sustains one per cycle.
- Ordering: in-order within a requester. Between requesters, RR order only; same rd in both FIFOs commits in grant order (hazard control is upstream).
- Simultaneous push and pop on one FIFO: both occur; count unchanged. Push into an empty FIFO cannot pop the same edge.
- Pointers wrap modulo DEPTH; full/empty via count of width log2(DEPTH)+1.
- Push when full cannot happen (ready low); valid with ready low is ignored, upstream holds.
- idle: combinational from registered state.

Test Plan:
- Reset then a_valid=1, a_rd=5, a_data=0xDEADBEEF one cycle -> write_enable=1, write_reg=5, write_data=0xDEADBEEF, grant_b=0 exactly one cycle after accept edge; idle back to 1 the cycle after.
- A and B valid every cycle (A: rd 1,2,3; B: rd 11,12,13) -> port sequence 1,11,2,12,3,13 with grant_b 0,1,0,1,0,1; no gaps.
- B alone, 4 back-to-back writes, DEPTH=2 -> b_ready stays 1, write_enable high 4 consecutive cycles, order preserved.
- A stream while B blocks A's grants half the time: fill A FIFO -> a_ready drops after 2 unpopped pushes, no data lost or duplicated; a_ready reasserts the cycle after a pop.
- a_rd=0 with a_data=0x1234 -> a_ready=1, handshake completes, write_enable never asserts, idle stays 1.
- Both FIFOs full, write_enable=1, assert rst_n low mid-cycle -> write_enable=0 and idle=1 immediately (async); after release no stale writes issue.
